// File: rtl/ecc_scalar_mult_ctrl.sv
// Double-and-add sequencer for Q = k*P; drives external doubler/adder over go/done handshakes.
// Optional build macro ECC_SCALAR_CONST_TIME_EN: fixed-schedule ladder (double and add on every bit).
module ecc_scalar_mult_ctrl #(
    parameter int integer_size = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic [integer_size-1:0] k,
    input  logic [integer_size-1:0] Px,
    input  logic [integer_size-1:0] Py,
    input  logic                    infiniteP,
    output logic                    busy,
    output logic                    done,
    output logic [integer_size-1:0] Qx,
    output logic [integer_size-1:0] Qy,
    output logic                    infiniteQ,
    output logic                    dbl_go,
    output logic [integer_size-1:0] dbl_Px,
    output logic [integer_size-1:0] dbl_Py,
    output logic                    dbl_infiniteP,
    input  logic                    dbl_done,
    input  logic [integer_size-1:0] dbl_doublePx,
    input  logic [integer_size-1:0] dbl_doublePy,
    input  logic                    dbl_infiniteDoubleP,
    output logic                    add_go,
    output logic [integer_size-1:0] add_Px,
    output logic [integer_size-1:0] add_Py,
    output logic [integer_size-1:0] add_Qx,
    output logic [integer_size-1:0] add_Qy,
    output logic                    add_infiniteP,
    output logic                    add_infiniteQ,
    input  logic                    add_done,
    input  logic [integer_size-1:0] add_Rx,
    input  logic [integer_size-1:0] add_Ry,
    input  logic                    add_infiniteR
);
    localparam int IW = (integer_size > 1) ? $clog2(integer_size) : 1;
    localparam logic [IW-1:0] I_TOP = IW'(integer_size - 1);

    typedef enum logic [2:0] {
        IDLE, SCAN, DBL_REQ, DBL_WAIT, ADD_CHECK, ADD_WAIT, NEXT, FINISH
    } state_t;

    state_t                  state;
    logic [integer_size-1:0] px_r, py_r, kreg, rx, ry;
    logic                    inf_p, inf_r;
    logic [IW-1:0]           i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            px_r          <= '0;
            py_r          <= '0;
            kreg          <= '0;
            inf_p         <= 1'b0;
            rx            <= '0;
            ry            <= '0;
            inf_r         <= 1'b0;
            i             <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            Qx            <= '0;
            Qy            <= '0;
            infiniteQ     <= 1'b0;
            dbl_go        <= 1'b0;
            dbl_Px        <= '0;
            dbl_Py        <= '0;
            dbl_infiniteP <= 1'b0;
            add_go        <= 1'b0;
            add_Px        <= '0;
            add_Py        <= '0;
            add_Qx        <= '0;
            add_Qy        <= '0;
            add_infiniteP <= 1'b0;
            add_infiniteQ <= 1'b0;
        end else begin
            done   <= 1'b0;
            dbl_go <= 1'b0;
            add_go <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    kreg  <= k;
                    px_r  <= Px;
                    py_r  <= Py;
                    inf_p <= infiniteP;
                    busy  <= 1'b1;
                    i     <= I_TOP;
`ifdef ECC_SCALAR_CONST_TIME_EN
                    rx    <= '0;
                    ry    <= '0;
                    inf_r <= 1'b1;
                    state <= DBL_REQ;
`else
                    state <= SCAN;
`endif
                end
`ifndef ECC_SCALAR_CONST_TIME_EN
                // Leading-one search: the first set bit loads R = P without any sub-unit call.
                SCAN: begin
                    if (kreg == '0 || inf_p) begin
                        inf_r <= 1'b1;
                        state <= FINISH;
                    end else if (kreg[i]) begin
                        rx    <= px_r;
                        ry    <= py_r;
                        inf_r <= 1'b0;
                        if (i == '0) state <= FINISH;
                        else begin
                            i     <= i - 1'b1;
                            state <= DBL_REQ;
                        end
                    end else begin
                        i <= i - 1'b1;
                    end
                end
`endif
                DBL_REQ: begin
`ifndef ECC_SCALAR_CONST_TIME_EN
                    if (inf_r) state <= ADD_CHECK;
                    else
`endif
                    begin
                        dbl_Px        <= rx;
                        dbl_Py        <= ry;
                        dbl_infiniteP <= inf_r;
                        dbl_go        <= 1'b1;
                        state         <= DBL_WAIT;
                    end
                end
                DBL_WAIT: if (dbl_done) begin
                    rx    <= dbl_doublePx;
                    ry    <= dbl_doublePy;
                    inf_r <= dbl_infiniteDoubleP;
                    state <= ADD_CHECK;
                end
                ADD_CHECK: begin
`ifndef ECC_SCALAR_CONST_TIME_EN
                    if (!kreg[i]) state <= NEXT;
                    else if (inf_r) begin
                        rx    <= px_r;
                        ry    <= py_r;
                        inf_r <= 1'b0;
                        state <= NEXT;
                    end else
`endif
                    begin
                        add_Px        <= rx;
                        add_Py        <= ry;
                        add_infiniteP <= inf_r;
                        add_Qx        <= px_r;
                        add_Qy        <= py_r;
                        add_infiniteQ <= inf_p;
                        add_go        <= 1'b1;
                        state         <= ADD_WAIT;
                    end
                end
                ADD_WAIT: if (add_done) begin
`ifdef ECC_SCALAR_CONST_TIME_EN
                    // Sum is always computed; the key bit only selects whether it is kept.
                    rx    <= kreg[i] ? add_Rx : rx;
                    ry    <= kreg[i] ? add_Ry : ry;
                    inf_r <= kreg[i] ? add_infiniteR : inf_r;
`else
                    rx    <= add_Rx;
                    ry    <= add_Ry;
                    inf_r <= add_infiniteR;
`endif
                    state <= NEXT;
                end
                NEXT: begin
                    if (i == '0) state <= FINISH;
                    else begin
                        i     <= i - 1'b1;
                        state <= DBL_REQ;
                    end
                end
                FINISH: begin
                    Qx        <= rx;
                    Qy        <= ry;
                    infiniteQ <= inf_r;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Bench for ecc_scalar_mult_ctrl on y^2 = x^3 + 2x + 2 mod 17 with behavioural doubler/adder.
module tb_ecc_scalar_mult_ctrl;
    localparam int W = 8;
    localparam int PR = 17;
    localparam int ORD = 19;

    typedef struct {int x; int y; bit inf;} pt_t;
    typedef struct {int kk; bit infp; int dl; int al; int ex; int ey; bit einf; int nd; int na;} vec_t;

    logic clk, rst, go, infiniteP, busy, done, infiniteQ;
    logic [W-1:0] k, Px, Py, Qx, Qy;
    logic dbl_go, dbl_infiniteP, dbl_done, dbl_infiniteDoubleP;
    logic [W-1:0] dbl_Px, dbl_Py, dbl_doublePx, dbl_doublePy;
    logic add_go, add_infiniteP, add_infiniteQ, add_done, add_infiniteR;
    logic [W-1:0] add_Px, add_Py, add_Qx, add_Qy, add_Rx, add_Ry;

    ecc_scalar_mult_ctrl #(.integer_size(W)) dut (
        .clk(clk), .rst(rst), .go(go), .k(k), .Px(Px), .Py(Py), .infiniteP(infiniteP),
        .busy(busy), .done(done), .Qx(Qx), .Qy(Qy), .infiniteQ(infiniteQ),
        .dbl_go(dbl_go), .dbl_Px(dbl_Px), .dbl_Py(dbl_Py), .dbl_infiniteP(dbl_infiniteP),
        .dbl_done(dbl_done), .dbl_doublePx(dbl_doublePx), .dbl_doublePy(dbl_doublePy),
        .dbl_infiniteDoubleP(dbl_infiniteDoubleP),
        .add_go(add_go), .add_Px(add_Px), .add_Py(add_Py), .add_Qx(add_Qx), .add_Qy(add_Qy),
        .add_infiniteP(add_infiniteP), .add_infiniteQ(add_infiniteQ), .add_done(add_done),
        .add_Rx(add_Rx), .add_Ry(add_Ry), .add_infiniteR(add_infiniteR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0, nchk = 0;
    int dlat = 1, alat = 1, dcnt, acnt;
    int n_dbl, n_add, n_done, overlap, stab_err, seq_code;
    logic [2*W:0] dsnap, asnap_p, asnap_q;
    pt_t dres, ares;

    function automatic int md(input int a);
        return ((a % PR) + PR) % PR;
    endfunction
    function automatic int inv(input int a);
        int r = 1;
        for (int e = 0; e < PR - 2; e++) r = md(r * a);
        return r;
    endfunction
    function automatic pt_t pdbl(input pt_t a);
        pt_t r;
        int lam;
        r = '{0, 0, 1'b1};
        if (a.inf || a.y == 0) return r;
        lam = md((3 * a.x * a.x + 2) * inv(md(2 * a.y)));
        r.x = md(lam * lam - 2 * a.x);
        r.y = md(lam * (a.x - r.x) - a.y);
        r.inf = 1'b0;
        return r;
    endfunction
    function automatic pt_t padd(input pt_t a, input pt_t b);
        pt_t r;
        int lam;
        if (a.inf) return b;
        if (b.inf) return a;
        r = '{0, 0, 1'b1};
        if (a.x == b.x) begin
            if (md(a.y + b.y) == 0) return r;
            return pdbl(a);
        end
        lam = md((b.y - a.y) * inv(md(b.x - a.x)));
        r.x = md(lam * lam - a.x - b.x);
        r.y = md(lam * (a.x - r.x) - a.y);
        r.inf = 1'b0;
        return r;
    endfunction
    function automatic pt_t mk(input logic [W-1:0] x, input logic [W-1:0] y, input logic inf);
        pt_t r;
        r.x = int'(x); r.y = int'(y); r.inf = inf;
        return r;
    endfunction
    // Reference result: k repeated additions of P.
    function automatic pt_t smul(input int kk, input pt_t p);
        pt_t r = '{0, 0, 1'b1};
        for (int n = 0; n < kk; n++) r = padd(r, p);
        return r;
    endfunction
    // Expected sub-unit calls, tracked through the multiple of P held so far.
    function automatic void ref_counts(input int kk, input bit infp, output int nd, output int na);
`ifdef ECC_SCALAR_CONST_TIME_EN
        nd = W; na = W;
`else
        int m, pre;
        nd = 0; na = 0;
        if (kk == 0 || infp) return;
        m = W - 1;
        while (((kk >> m) & 1) == 0) m--;
        pre = 1;
        for (int b = m - 1; b >= 0; b--) begin
            if (pre % ORD != 0) nd++;
            pre = pre * 2;
            if (((kk >> b) & 1) == 1) begin
                if (pre % ORD != 0) na++;
                pre = pre + 1;
            end
        end
`endif
    endfunction

    // Doubler / adder responders with programmable latency.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt <= 0; acnt <= 0; dbl_done <= 1'b0; add_done <= 1'b0;
            dbl_doublePx <= '0; dbl_doublePy <= '0; dbl_infiniteDoubleP <= 1'b0;
            add_Rx <= '0; add_Ry <= '0; add_infiniteR <= 1'b0;
        end else begin
            dbl_done <= 1'b0;
            add_done <= 1'b0;
            if (dcnt > 0) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1) begin
                    dbl_done <= 1'b1;
                    dbl_doublePx <= W'(dres.x); dbl_doublePy <= W'(dres.y);
                    dbl_infiniteDoubleP <= dres.inf;
                end
            end else if (dbl_go) begin
                dcnt  <= dlat;
                dres  <= pdbl(mk(dbl_Px, dbl_Py, dbl_infiniteP));
                dsnap <= {dbl_infiniteP, dbl_Px, dbl_Py};
            end
            if (acnt > 0) begin
                acnt <= acnt - 1;
                if (acnt == 1) begin
                    add_done <= 1'b1;
                    add_Rx <= W'(ares.x); add_Ry <= W'(ares.y); add_infiniteR <= ares.inf;
                end
            end else if (add_go) begin
                acnt    <= alat;
                ares    <= padd(mk(add_Px, add_Py, add_infiniteP), mk(add_Qx, add_Qy, add_infiniteQ));
                asnap_p <= {add_infiniteP, add_Px, add_Py};
                asnap_q <= {add_infiniteQ, add_Qx, add_Qy};
            end
        end
    end

    always @(posedge clk) begin
        if (dbl_go) begin n_dbl++; seq_code = seq_code * 4 + 1; end
        if (add_go) begin n_add++; seq_code = seq_code * 4 + 2; end
        if (dbl_go && add_go) overlap++;
        if (done) n_done++;
        if (dcnt > 0 && {dbl_infiniteP, dbl_Px, dbl_Py} != dsnap) stab_err++;
        if (acnt > 0 && ({add_infiniteP, add_Px, add_Py} != asnap_p ||
                         {add_infiniteQ, add_Qx, add_Qy} != asnap_q)) stab_err++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic start_op(input int kk, input pt_t p);
        @(negedge clk);
        n_dbl = 0; n_add = 0; n_done = 0; overlap = 0; stab_err = 0; seq_code = 0;
        k = W'(kk); Px = W'(p.x); Py = W'(p.y); infiniteP = p.inf;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 1; ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic finish_checks(input string nm, input pt_t eq, input int end_, input int ena);
        chk({nm, "_busy_at_done"}, int'(busy), 0);
        chk({nm, "_infQ"}, int'(infiniteQ), int'(eq.inf));
        if (!eq.inf) begin
            chk({nm, "_Qx"}, int'(Qx), eq.x);
            chk({nm, "_Qy"}, int'(Qy), eq.y);
        end
        chk({nm, "_n_dbl"}, n_dbl, end_);
        chk({nm, "_n_add"}, n_add, ena);
        chk({nm, "_go_overlap"}, overlap, 0);
        chk({nm, "_operand_stable"}, stab_err, 0);
        repeat (3) @(negedge clk);
        chk({nm, "_done_count"}, n_done, 1);
    endtask

    task automatic run_check(input string nm, input int kk, input pt_t p, input int dl, input int al,
                             input pt_t eq, input int end_, input int ena, output int cyc);
        bit ok;
        dlat = dl; alat = al;
        start_op(kk, p);
        chk({nm, "_busy"}, int'(busy), 1);
        wait_done(cyc, ok);
        chk({nm, "_done_seen"}, int'(ok), 1);
        finish_checks(nm, eq, end_, ena);
    endtask

    vec_t tbl[12];
    pt_t g, p, eq;
    int nd, na, cyc, cyc2;
    bit ok;

    initial begin
        g = '{5, 1, 1'b0};
        tbl[0]  = '{1,   1'b0, 3,  3, 5,  1,  1'b0, 0, 0};
        tbl[1]  = '{5,   1'b0, 1,  1, 9,  16, 1'b0, 2, 1};
        tbl[2]  = '{5,   1'b0, 20, 7, 9,  16, 1'b0, 2, 1};
        tbl[3]  = '{19,  1'b0, 2,  4, 0,  0,  1'b1, 4, 2};
        tbl[4]  = '{0,   1'b0, 1,  1, 0,  0,  1'b1, 0, 0};
        tbl[5]  = '{2,   1'b0, 4,  2, 6,  3,  1'b0, 1, 0};
        tbl[6]  = '{3,   1'b0, 2,  5, 10, 6,  1'b0, 1, 1};
        tbl[7]  = '{6,   1'b0, 6,  1, 16, 13, 1'b0, 2, 1};
        tbl[8]  = '{9,   1'b0, 1,  2, 7,  6,  1'b0, 3, 1};
        tbl[9]  = '{20,  1'b0, 3,  3, 5,  1,  1'b0, 4, 1};
        tbl[10] = '{5,   1'b1, 2,  2, 0,  0,  1'b1, 0, 0};
        tbl[11] = '{255, 1'b0, 1,  1, 13, 7,  1'b0, 7, 7};

        rst = 1'b1; go = 1'b0; k = '0; Px = '0; Py = '0; infiniteP = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({busy, done, Qx, Qy, infiniteQ, dbl_go, add_go}), 0);
        chk("reset_operands", int'({dbl_Px, dbl_Py, dbl_infiniteP, add_Px, add_Py,
                                    add_Qx, add_Qy, add_infiniteP, add_infiniteQ}), 0);
        rst = 1'b0;

        for (int j = 0; j < 12; j++) begin
            p = g; p.inf = tbl[j].infp;
            eq = '{tbl[j].ex, tbl[j].ey, tbl[j].einf};
            nd = tbl[j].nd; na = tbl[j].na;
`ifdef ECC_SCALAR_CONST_TIME_EN
            nd = W; na = W;
`endif
            run_check($sformatf("vec%0d_k%0d", j, tbl[j].kk), tbl[j].kk, p, tbl[j].dl, tbl[j].al,
                      eq, nd, na, cyc);
`ifndef ECC_SCALAR_CONST_TIME_EN
            if (j == 1) chk("k5_order_dbl_dbl_add", seq_code, 22);
            if (j == 4) chk("k0_latency_bound", int'(cyc <= W + 3), 1);
`endif
        end

        // Second go while the doubler is busy must be ignored.
        dlat = 6; alat = 3;
        start_op(7, g);
        for (int c = 0; c < 200 && n_dbl == 0; c++) @(negedge clk);
        chk("rego_dbl_started", int'(n_dbl > 0), 1);
        k = 8'd1; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done(cyc, ok);
        chk("rego_done_seen", int'(ok), 1);
        eq = '{0, 6, 1'b0};
        ref_counts(7, 1'b0, nd, na);
        finish_checks("rego_k7", eq, nd, na);

        // Async reset in the middle of an adder call.
        run_check("pre_rst_k3", 3, g, 1, 1, '{10, 6, 1'b0}, 1, 1, cyc);
        dlat = 2; alat = 10;
        start_op(10, g);
        for (int c = 0; c < 300 && n_add == 0; c++) @(negedge clk);
        chk("rst_add_started", int'(n_add > 0), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", int'({busy, done, Qx, Qy, infiniteQ, dbl_go, add_go}), 0);
        @(negedge clk);
        rst = 1'b0;
        ref_counts(2, 1'b0, nd, na);
        run_check("post_rst_k2", 2, g, 3, 3, '{6, 3, 1'b0}, nd, na, cyc);

`ifdef ECC_SCALAR_CONST_TIME_EN
        run_check("ct_k5", 5, g, 3, 4, smul(5, g), W, W, cyc);
        run_check("ct_k128", 128, g, 3, 4, smul(128, g), W, W, cyc2);
        chk("ct_equal_cycles", cyc2, cyc);
`endif

        // Random scalars and base points against the repeated-addition model.
        for (int r = 0; r < 15; r++) begin
            int kk, m;
            kk = $urandom_range(0, 255);
            m = $urandom_range(1, 18);
            p = smul(m, g);
            p.inf = ($urandom_range(0, 7) == 0);
            eq = p.inf ? '{0, 0, 1'b1} : smul(kk, p);
            ref_counts(kk, p.inf, nd, na);
            run_check($sformatf("rnd%0d_k%0d_m%0d", r, kk, m), kk, p,
                      $urandom_range(1, 20), $urandom_range(1, 20), eq, nd, na, cyc);
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
